// File: rtl/systolic_mac_pe_pkg.sv
// Shared types and helpers for the systolic processing element.
// Latency: n/a (types, constants and a combinational add helper).
// Backpressure: n/a.
package systolic_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  // Headroom bits above a full-width product in the default accumulator.
  localparam int ACC_GUARD  = DEF_ACC_W - 2*DEF_DATA_W;
  // Widest accumulator the add helper supports (ACC_W must stay below this).
  localparam int ACC_MAX_W  = 64;

  typedef logic [ACC_MAX_W-1:0] acc_max_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } pe_state_e;

  // Adds two w-bit values held in the low bits of 64-bit containers.
  // Returns {sum, ovf}: overflow is same-sign overflow for signed operands
  // and carry-out for unsigned ones; with saturate set, the sum is clamped
  // to the representable extreme in the direction of the overflow.
  function automatic logic [ACC_MAX_W:0] acc_add(
    input acc_max_t a,
    input acc_max_t b,
    input int       w,
    input logic     is_signed,
    input logic     saturate
  );
    acc_max_t           mask;
    acc_max_t           x;
    acc_max_t           y;
    acc_max_t           sum;
    acc_max_t           tmp;
    logic [ACC_MAX_W:0] full;
    logic [ACC_MAX_W:0] full_sh;
    logic               sa;
    logic               sb;
    logic               ss;
    logic               carry;
    logic               ovf;
    mask    = (w >= ACC_MAX_W) ? '1 : ((acc_max_t'(1) << w) - acc_max_t'(1));
    x       = a & mask;
    y       = b & mask;
    full    = {1'b0, x} + {1'b0, y};
    sum     = full[ACC_MAX_W-1:0] & mask;
    full_sh = full >> w;
    carry   = full_sh[0];
    tmp     = x >> (w - 1);
    sa      = tmp[0];
    tmp     = y >> (w - 1);
    sb      = tmp[0];
    tmp     = sum >> (w - 1);
    ss      = tmp[0];
    if (is_signed) begin
      ovf = (sa == sb) && (ss != sa);
    end else begin
      ovf = carry;
    end
    if (ovf && saturate) begin
      if (!is_signed) begin
        sum = mask;
      end else if (sa) begin
        sum = mask ^ (mask >> 1);
      end else begin
        sum = mask >> 1;
      end
    end
    return {sum, ovf};
  endfunction

endpackage

// File: rtl/systolic_mac_pe_mac_unit.sv
// Two-stage multiply-accumulate: product register, then extend-and-add.
// Latency: an operand pair shows up in the accumulator 2 cycles after it is presented.
// Backpressure: none; accepts a pair every cycle, clears override the add.
module pe_mac_unit
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_pair_vld,
  input  logic              i_acc_clear,
  input  logic              i_emit_clr,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_prod_v,
  output logic              o_sat
);

  logic [2*DATA_W-1:0]        w_prod;
  logic [2*DATA_W-1:0]        r_prod;
  logic                       r_prod_v;
  logic [ACC_W-1:0]           w_ext;
  logic [ACC_W-1:0]           r_acc;
  logic                       r_sat;
  logic [ACC_MAX_W:0]         w_add;
  logic [ACC_W-1:0]           w_sum;
  logic                       w_ovf;
  logic [ACC_MAX_W-ACC_W-1:0] w_unused_hi;

  // Full-width product of the presented pair in the configured signedness.
  always_comb begin
    w_prod = '0;
    if (SIGNED != 0) begin
      w_prod = $signed(i_a) * $signed(i_b);
    end else begin
      w_prod = i_a * i_b;
    end
  end

  // Widen the registered product to accumulator width.
  always_comb begin
    w_ext = '0;
    if (SIGNED != 0) begin
      w_ext = ACC_W'($signed(r_prod));
    end else begin
      w_ext = ACC_W'(r_prod);
    end
  end

  assign w_add       = acc_add(acc_max_t'(r_acc), acc_max_t'(w_ext), ACC_W,
                               (SIGNED != 0), (SATURATE != 0));
  assign w_sum       = w_add[ACC_W:1];
  assign w_ovf       = w_add[0];
  assign w_unused_hi = w_add[ACC_MAX_W:ACC_W+1];

  // Stage 1: capture the product whenever both operands are valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod   <= '0;
      r_prod_v <= 1'b0;
    end else begin
      r_prod_v <= i_pair_vld;
      if (i_pair_vld) begin
        r_prod <= w_prod;
      end
    end
  end

  // Stage 2: accumulate; a clear wins over the add and drops that product.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_acc_clear || i_emit_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (r_prod_v) begin
      r_acc <= w_sum;
      if (w_ovf) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_acc    = r_acc;
  assign o_prod_v = r_prod_v;
  assign o_sat    = r_sat;

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic PE: operand forwarding, MAC and column drain chain.
// Latency: operands forwarded in 1 cycle; accumulate in 2; drain hop 1 cycle per PE.
// Backpressure: none; a drain request waits (busy_o) until the MAC pipe is empty.
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = 2*DEF_DATA_W + ACC_GUARD,
  parameter int SIGNED      = 1,
  parameter int SATURATE    = 1,
  parameter int DRAIN_DEPTH = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_clear,
  input  logic [DATA_W-1:0] a_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              b_valid_i,
  output logic [DATA_W-1:0] a_o,
  output logic              a_valid_o,
  output logic [DATA_W-1:0] b_o,
  output logic              b_valid_o,
  input  logic              drain_i,
  input  logic [ACC_W-1:0]  drain_d_i,
  input  logic              drain_valid_i,
  output logic [ACC_W-1:0]  drain_d_o,
  output logic              drain_valid_o,
  output logic              busy_o,
  output logic              sat_o
);

  localparam int CNT_W = (DRAIN_DEPTH > 0) ? $clog2(DRAIN_DEPTH + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DRAIN_DEPTH > 0) ? DRAIN_DEPTH - 1 : 0);

  logic [DATA_W-1:0] r_a;
  logic              r_a_vld;
  logic [DATA_W-1:0] r_b;
  logic              r_b_vld;
  logic [ACC_W-1:0]  r_drain_d;
  logic              r_drain_vld;
  logic              r_pending;
  pe_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_pair;
  logic              w_mac_clear;
  logic              w_emit;
  logic [ACC_W-1:0]  w_acc;
  logic              w_prod_v;
  logic              w_sat;

  assign w_pair      = a_valid_i & b_valid_i;
  // The accumulator is being handed off while draining, so user clears are dropped.
  assign w_mac_clear = acc_clear & (r_state != DRAIN);
  assign w_emit      = (r_state == EMIT);

  pe_mac_unit #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_mac (
    .clk         (clk),
    .reset       (reset),
    .i_a         (a_i),
    .i_b         (b_i),
    .i_pair_vld  (w_pair),
    .i_acc_clear (w_mac_clear),
    .i_emit_clr  (w_emit),
    .o_acc       (w_acc),
    .o_prod_v    (w_prod_v),
    .o_sat       (w_sat)
  );

  // Forward operands east/south every cycle, regardless of valid or state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_a_vld <= 1'b0;
      r_b     <= '0;
      r_b_vld <= 1'b0;
    end else begin
      r_a     <= a_i;
      r_a_vld <= a_valid_i;
      r_b     <= b_i;
      r_b_vld <= b_valid_i;
    end
  end

  // Drain FSM: wait for an empty MAC pipe, emit own result, then relay upstream results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ACCUM;
      r_pending   <= 1'b0;
      r_cnt       <= '0;
      r_drain_d   <= '0;
      r_drain_vld <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_drain_vld <= 1'b0;
          if (r_pending) begin
            // The in-flight product lands this edge; enter EMIT unless a new pair arrives.
            if (!w_pair) begin
              r_state   <= EMIT;
              r_pending <= 1'b0;
            end
          end else if (drain_i) begin
            if (!w_pair && !w_prod_v) begin
              r_state <= EMIT;
            end else begin
              r_pending <= 1'b1;
            end
          end
        end
        EMIT: begin
          r_drain_d   <= w_acc;
          r_drain_vld <= 1'b1;
          r_cnt       <= '0;
          r_state     <= (DRAIN_DEPTH > 0) ? DRAIN : ACCUM;
        end
        DRAIN: begin
          r_drain_d   <= drain_d_i;
          r_drain_vld <= drain_valid_i;
          if (drain_valid_i) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= ACCUM;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= ACCUM;
          r_drain_vld <= 1'b0;
        end
      endcase
    end
  end

  assign a_o           = r_a;
  assign a_valid_o     = r_a_vld;
  assign b_o           = r_b;
  assign b_valid_o     = r_b_vld;
  assign drain_d_o     = r_drain_d;
  assign drain_valid_o = r_drain_vld;
  assign busy_o        = r_pending | (r_state != ACCUM);
  assign sat_o         = w_sat;

endmodule

// File: tb/tb_systolic_mac_pe.sv
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_clear;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        a_valid;
  logic        b_valid;
  logic        drain_i;
  logic [19:0] drain_d_i;
  logic        drain_valid_i;

  int n_tests = 0;
  int n_fail  = 0;

  // u_s: DATA_W=8, ACC_W=20, signed, saturating, no upstream PEs
  logic [7:0]  s_a_o, s_b_o;
  logic        s_a_vld, s_b_vld, s_dv, s_busy, s_sat;
  logic [19:0] s_dd;
  // u_p: DATA_W=8, ACC_W=16, saturating, two upstream PEs
  logic [7:0]  p_a_o, p_b_o;
  logic        p_a_vld, p_b_vld, p_dv, p_busy, p_sat;
  logic [15:0] p_dd;
  // u_q: DATA_W=8, ACC_W=16, wrapping
  logic [7:0]  q_a_o, q_b_o;
  logic        q_a_vld, q_b_vld, q_dv, q_busy, q_sat;
  logic [15:0] q_dd;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SATURATE(1), .DRAIN_DEPTH(0)) u_s (
    .clk(clk), .reset(reset), .acc_clear(acc_clear),
    .a_i(a), .a_valid_i(a_valid), .b_i(b), .b_valid_i(b_valid),
    .a_o(s_a_o), .a_valid_o(s_a_vld), .b_o(s_b_o), .b_valid_o(s_b_vld),
    .drain_i(drain_i), .drain_d_i(drain_d_i), .drain_valid_i(drain_valid_i),
    .drain_d_o(s_dd), .drain_valid_o(s_dv), .busy_o(s_busy), .sat_o(s_sat)
  );

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .DRAIN_DEPTH(2)) u_p (
    .clk(clk), .reset(reset), .acc_clear(acc_clear),
    .a_i(a), .a_valid_i(a_valid), .b_i(b), .b_valid_i(b_valid),
    .a_o(p_a_o), .a_valid_o(p_a_vld), .b_o(p_b_o), .b_valid_o(p_b_vld),
    .drain_i(drain_i), .drain_d_i(drain_d_i[15:0]), .drain_valid_i(drain_valid_i),
    .drain_d_o(p_dd), .drain_valid_o(p_dv), .busy_o(p_busy), .sat_o(p_sat)
  );

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0), .DRAIN_DEPTH(0)) u_q (
    .clk(clk), .reset(reset), .acc_clear(acc_clear),
    .a_i(a), .a_valid_i(a_valid), .b_i(b), .b_valid_i(b_valid),
    .a_o(q_a_o), .a_valid_o(q_a_vld), .b_o(q_b_o), .b_valid_o(q_b_vld),
    .drain_i(drain_i), .drain_d_i(drain_d_i[15:0]), .drain_valid_i(drain_valid_i),
    .drain_d_o(q_dd), .drain_valid_o(q_dv), .busy_o(q_busy), .sat_o(q_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a = '0; b = '0; a_valid = 1'b0; b_valid = 1'b0;
    drain_i = 1'b0; acc_clear = 1'b0; drain_valid_i = 1'b0; drain_d_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pair(input logic [7:0] x, input logic [7:0] y);
    a = x; b = y; a_valid = 1'b1; b_valid = 1'b1;
  endtask

  task automatic nopair();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (s_a_vld !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %0b want 0", s_a_vld); end
    n_tests++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL reset_drain_valid: got %0b want 0", s_dv); end
    n_tests++; if (s_dd !== 20'h0) begin n_fail++; $display("FAIL reset_drain_d: got %0h want 0", s_dd); end
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", s_busy); end
    n_tests++; if (p_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b want 0", p_sat); end
    n_tests++; if (p_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_chain: got %0b want 0", p_busy); end
  endtask

  task automatic test_forwarding();
    do_reset();
    a = 8'h05; a_valid = 1'b1; b = 8'hFE; b_valid = 1'b0;
    tick();
    n_tests++; if (s_a_o !== 8'h05) begin n_fail++; $display("FAIL fwd_a: got %0h want 05", s_a_o); end
    n_tests++; if (s_a_vld !== 1'b1) begin n_fail++; $display("FAIL fwd_a_valid: got %0b want 1", s_a_vld); end
    n_tests++; if (s_b_o !== 8'hFE) begin n_fail++; $display("FAIL fwd_b: got %0h want fe", s_b_o); end
    n_tests++; if (s_b_vld !== 1'b0) begin n_fail++; $display("FAIL fwd_b_valid: got %0b want 0", s_b_vld); end
    a = 8'h80; a_valid = 1'b0; b = 8'h01; b_valid = 1'b1;
    tick();
    n_tests++; if (s_a_o !== 8'h80) begin n_fail++; $display("FAIL fwd2_a: got %0h want 80", s_a_o); end
    n_tests++; if (s_a_vld !== 1'b0) begin n_fail++; $display("FAIL fwd2_a_valid: got %0b want 0", s_a_vld); end
    n_tests++; if (s_b_o !== 8'h01) begin n_fail++; $display("FAIL fwd2_b: got %0h want 01", s_b_o); end
    n_tests++; if (s_b_vld !== 1'b1) begin n_fail++; $display("FAIL fwd2_b_valid: got %0b want 1", s_b_vld); end
    idle_inputs();
  endtask

  task automatic test_mac_signed();
    do_reset();
    pair(8'd2, 8'd3); tick();
    pair(8'hFC, 8'd5); tick();
    pair(8'd7, 8'd7); tick();
    nopair(); tick(); tick();
    drain_i = 1'b1; tick();
    n_tests++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL mac_busy_emit: got %0b want 1", s_busy); end
    n_tests++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL mac_valid_early: got %0b want 0", s_dv); end
    drain_i = 1'b0; tick();
    n_tests++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL mac_valid: got %0b want 1", s_dv); end
    n_tests++; if (s_dd !== 20'h00023) begin n_fail++; $display("FAIL mac_sum: got %0h want 23", s_dd); end
    tick();
    n_tests++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL mac_valid_one_cycle: got %0b want 0", s_dv); end
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL mac_busy_done: got %0b want 0", s_busy); end
    drain_i = 1'b1; tick();
    drain_i = 1'b0; tick();
    n_tests++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL mac_redrain_valid: got %0b want 1", s_dv); end
    n_tests++; if (s_dd !== 20'h0) begin n_fail++; $display("FAIL mac_acc_cleared: got %0h want 0", s_dd); end
  endtask

  task automatic test_saturation();
    logic [7:0]  xa [2];
    logic [7:0]  xb [2];
    logic [15:0] want_sat [2];
    logic [15:0] want_wrap [2];
    xa[0] = 8'h7F; xb[0] = 8'h7F; want_sat[0] = 16'h7FFF; want_wrap[0] = 16'hBD03;
    xa[1] = 8'h80; xb[1] = 8'h7F; want_sat[1] = 16'h8000; want_wrap[1] = 16'h4180;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      pair(xa[k], xb[k]); tick(); tick(); tick();
      n_tests++; if (p_sat !== 1'b0) begin n_fail++; $display("FAIL sat_early[%0d]: got %0b want 0", k, p_sat); end
      nopair(); tick();
      n_tests++; if (p_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag[%0d]: got %0b want 1", k, p_sat); end
      n_tests++; if (q_sat !== 1'b1) begin n_fail++; $display("FAIL wrap_flag[%0d]: got %0b want 1", k, q_sat); end
      tick();
      drain_i = 1'b1; tick();
      drain_i = 1'b0; tick();
      n_tests++; if (p_dd !== want_sat[k]) begin n_fail++; $display("FAIL sat_value[%0d]: got %0h want %0h", k, p_dd, want_sat[k]); end
      n_tests++; if (q_dd !== want_wrap[k]) begin n_fail++; $display("FAIL wrap_value[%0d]: got %0h want %0h", k, q_dd, want_wrap[k]); end
      n_tests++; if (q_dv !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %0b want 1", k, q_dv); end
      n_tests++; if (p_sat !== 1'b0) begin n_fail++; $display("FAIL sat_cleared_by_emit[%0d]: got %0b want 0", k, p_sat); end
    end
  endtask

  task automatic test_pending_drain();
    do_reset();
    pair(8'd2, 8'd5); tick();
    nopair(); tick(); tick();
    pair(8'd3, 8'd3); drain_i = 1'b1; tick();
    n_tests++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy: got %0b want 1", s_busy); end
    nopair(); drain_i = 1'b0; tick();
    n_tests++; if (s_dv !== 1'b0) begin n_fail++; $display("FAIL pend_not_yet: got %0b want 0", s_dv); end
    n_tests++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy_emit: got %0b want 1", s_busy); end
    tick();
    n_tests++; if (s_dv !== 1'b1) begin n_fail++; $display("FAIL pend_valid: got %0b want 1", s_dv); end
    n_tests++; if (s_dd !== 20'd19) begin n_fail++; $display("FAIL pend_value: got %0d want 19", s_dd); end
    tick();
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL pend_busy_done: got %0b want 0", s_busy); end
  endtask

  task automatic test_chain();
    do_reset();
    pair(8'd7, 8'd1); tick();
    nopair(); tick(); tick();
    drain_i = 1'b1; tick();
    drain_i = 1'b0; tick();
    n_tests++; if (p_dv !== 1'b1 || p_dd !== 16'd7) begin n_fail++; $display("FAIL chain_own: got v=%0b d=%0d want v=1 d=7", p_dv, p_dd); end
    drain_d_i = 20'd11; drain_valid_i = 1'b1; tick();
    n_tests++; if (p_dv !== 1'b1 || p_dd !== 16'd11) begin n_fail++; $display("FAIL chain_fwd1: got v=%0b d=%0d want v=1 d=11", p_dv, p_dd); end
    n_tests++; if (p_busy !== 1'b1) begin n_fail++; $display("FAIL chain_busy: got %0b want 1", p_busy); end
    drain_d_i = 20'd13; tick();
    n_tests++; if (p_dv !== 1'b1 || p_dd !== 16'd13) begin n_fail++; $display("FAIL chain_fwd2: got v=%0b d=%0d want v=1 d=13", p_dv, p_dd); end
    drain_valid_i = 1'b0; drain_d_i = '0; tick();
    n_tests++; if (p_dv !== 1'b0) begin n_fail++; $display("FAIL chain_end_valid: got %0b want 0", p_dv); end
    n_tests++; if (p_busy !== 1'b0) begin n_fail++; $display("FAIL chain_end_busy: got %0b want 0", p_busy); end
    drain_i = 1'b1; tick();
    n_tests++; if (p_busy !== 1'b1) begin n_fail++; $display("FAIL chain_redrain_busy: got %0b want 1", p_busy); end
    drain_i = 1'b0; tick();
    n_tests++; if (p_dv !== 1'b1 || p_dd !== 16'd0) begin n_fail++; $display("FAIL chain_redrain: got v=%0b d=%0d want v=1 d=0", p_dv, p_dd); end
  endtask

  task automatic test_reset_and_clear();
    do_reset();
    drain_i = 1'b1; tick();
    drain_i = 1'b0; pair(8'h7F, 8'h7F); tick(); tick(); tick();
    nopair(); tick(); tick();
    n_tests++; if (p_sat !== 1'b1) begin n_fail++; $display("FAIL drain_sat_set: got %0b want 1", p_sat); end
    acc_clear = 1'b1; tick();
    acc_clear = 1'b0;
    n_tests++; if (p_sat !== 1'b1) begin n_fail++; $display("FAIL clear_ignored_in_drain: got %0b want 1", p_sat); end
    drain_d_i = 20'd5; drain_valid_i = 1'b1; tick();
    n_tests++; if (p_dv !== 1'b1 || p_dd !== 16'd5) begin n_fail++; $display("FAIL drain_fwd_before_reset: got v=%0b d=%0d want v=1 d=5", p_dv, p_dd); end
    reset = 1'b1; tick();
    n_tests++; if (p_dv !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drain_valid: got %0b want 0", p_dv); end
    n_tests++; if (p_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drain_busy: got %0b want 0", p_busy); end
    n_tests++; if (p_sat !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drain_sat: got %0b want 0", p_sat); end
    reset = 1'b0; tick();
    n_tests++; if (p_dv !== 1'b0) begin n_fail++; $display("FAIL no_pulse_after_reset: got %0b want 0", p_dv); end
    idle_inputs();
    do_reset();
    pair(8'd5, 8'd6); tick();
    nopair(); acc_clear = 1'b1; tick();
    acc_clear = 1'b0; tick();
    drain_i = 1'b1; tick();
    drain_i = 1'b0; tick();
    n_tests++; if (s_dv !== 1'b1 || s_dd !== 20'd0) begin n_fail++; $display("FAIL clear_inflight: got v=%0b d=%0d want v=1 d=0", s_dv, s_dd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_mac_signed();
    test_saturation();
    test_pending_drain();
    test_chain();
    test_reset_and_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
- Parametrised output-stationary processing element for the matrix accelerator's systolic array.
- Forwards valid-qualified operands east/south with one cycle of latency.
- Accumulates products in a pipelined MAC with selectable signedness and saturation, and keeps a sticky overflow flag.
- Results leave through a column drain chain driven by a per-PE counter, so the array can drain while new accumulation starts.

Parameters:
- DATA_W, 16, operand width.
- ACC_W, 40, accumulator width; must be >= 2*DATA_W.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W.
- DRAIN_DEPTH, 0, number of upstream PEs whose results this PE forwards on the drain chain.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- acc_clear  in  1  clear accumulator and sat_o
- a_i  in  DATA_W  west operand
- a_valid_i  in  1  west operand valid
- b_i  in  DATA_W  north operand
- b_valid_i  in  1  north operand valid
- a_o  out  DATA_W  east operand (registered)
- a_valid_o  out  1  east valid
- b_o  out  DATA_W  south operand (registered)
- b_valid_o  out  1  south valid
- drain_i  in  1  drain request pulse
- drain_d_i  in  ACC_W  drain chain data from upstream PE
- drain_valid_i  in  1  drain chain valid from upstream PE
- drain_d_o  out  ACC_W  drain chain data out
- drain_valid_o  out  1  drain chain valid out
- busy_o  out  1  high while drain is pending or in progress
- sat_o  out  1  sticky overflow flag

Behaviour:
- Reset (already decided):
  - reset is synchronous, active-high; clock is clk.
  - All outputs, accumulator, product register and counter go to 0; state = ACCUM.
  - reset mid-drain aborts the drain immediately; no further drain_valid_o pulses.
- Operand forwarding:
  - a_o/a_valid_o and b_o/b_valid_o register a_i/a_valid_i and b_i/b_valid_i every cycle, in every state.
  - Data is forwarded even when the matching valid is low.
- MAC pipeline:
  - Stage 1: when a_valid_i & b_valid_i, register the 2*DATA_W product (signed or unsigned per SIGNED) and set prod_v.
  - Stage 2: when prod_v, extend the product to ACC_W (sign-extend if SIGNED, else zero-extend) and add it to the accumulator.
  - Latency: an operand pair is reflected in the accumulator 2 cycles after it is presented.
- Overflow:
  - Detected on the ACC_W-bit add: same-sign overflow when SIGNED, carry-out when unsigned.
  - SATURATE=1: clamp to max/min representable value.
  - SATURATE=0: result wraps.
  - sat_o is set on overflow in either mode and stays high until acc_clear, reset, or the PE's own result is emitted.
- acc_clear:
  - Zeroes the accumulator and sat_o and discards any in-flight product.
  - Takes priority over the same-cycle add.
  - Ignored while state = DRAIN.
- States:
  - ACCUM: normal accumulation. On drain_i, if prod_v = 0 and no operand pair is presented that cycle, go to EMIT. Otherwise set a pending flag (busy_o = 1) and go to EMIT on the first cycle the MAC pipeline is empty.
  - EMIT (one cycle):
    - drain_d_o <= accumulator (including all accepted products), drain_valid_o <= 1.
    - Accumulator <= 0 and sat_o <= 0.
    - Then go to DRAIN if DRAIN_DEPTH > 0, else ACCUM.
    - Operand pairs presented during EMIT accumulate into the fresh accumulator.
  - DRAIN:
    - drain_d_o/drain_valid_o register drain_d_i/drain_valid_i (1-cycle hop).
    - Counter increments on each drain_valid_i.
    - When the count reaches DRAIN_DEPTH, return to ACCUM (the last forward is still emitted) and clear the counter.
    - Accumulation continues normally.
    - drain_i in DRAIN is ignored.
- drain_valid_o is 0 in ACCUM.
- busy_o = pending | EMIT | DRAIN.

Decomposition:
- Package systolic_pkg:
  - pe_state_e enum (ACCUM, EMIT, DRAIN).
  - Function for the extended, overflow-checked add returning {sum, ovf}.
  - Constant ACC_GUARD = ACC_W - 2*DATA_W.
- Sub-module pe_mac_unit:
  - Contains the product register, extension, saturating accumulate, acc_clear and the emit-clear port.
  - Parent holds forwarding, FSM, counter and drain chain.

Test Plan:
- Forwarding, DATA_W=8: a_i=0x05, a_valid_i=1, b_i=0xFE, b_valid_i=0 -> next cycle a_o=0x05, a_valid_o=1, b_o=0xFE, b_valid_o=0.
- MAC signed, DATA_W=8, ACC_W=20: pairs (2,3),(-4,5),(7,7) on consecutive cycles, then drain_i two cycles later -> drain_d_o=0x00023 (35), drain_valid_o=1 for one cycle; accumulator reads 0 afterwards.
- Saturation, ACC_W=16, SATURATE=1: three pairs (127,127) -> result 0x7FFF, sat_o=1; with SATURATE=0, same stimulus -> 0xBD03 (48387 mod 2^16 as signed), sat_o=1.
- Pending drain: drain_i in the same cycle as the final pair (3,3) on accumulator 10 -> busy_o=1 immediately; emitted value 19, two cycles after drain_i rather than one.
- Chain, DRAIN_DEPTH=2: own accumulator 7, upstream drain_d_i 11 then 13 with valid -> drain_d_o sequence 7, 11, 13 on valid cycles; busy_o low the cycle after 13 is emitted; a later drain_i is accepted.
- Reset and clear: reset asserted during DRAIN after one forward -> next cycle drain_valid_o=0, busy_o=0, sat_o=0; acc_clear during DRAIN ignored, acc_clear in ACCUM with a product in flight -> accumulator 0.
